// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: grants one of NREQ requesters per cycle and registers the write.
// Build option RF_ARB_RR_EN selects round-robin arbitration; without it, fixed priority (lowest index wins).
module rf_wr_arb #(
    parameter int unsigned NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [4*NREQ-1:0]    req_addr,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_rdy,
    output logic                 we,
    output logic [3:0]           dst_addr,
    output logic [15:0]          dst,
    input  logic                 hlt,
    output logic                 hlt_done,
    output logic [7:0]           drop_cnt
);

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [NREQ-1:0] gnt;
    logic            grant_en;
    logic            accept;
    logic            wr_live;
    logic            wr_drop;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // Grants only in RUN and never in the cycle hlt is seen.
    assign grant_en = (state == ST_RUN) && !hlt;

`ifdef RF_ARB_RR_EN
    logic [IW-1:0] ptr;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] sel_idx;

    // Search starts at ptr, which holds the requester after the last one granted.
    always_comb begin
        gnt    = '0;
        rr_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = IW'((int'(ptr) + k) % NREQ);
            if (gnt == '0 && req_vld[rr_idx]) begin
                gnt[rr_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_idx = IW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= IW'((int'(sel_idx) + 1) % NREQ);
        end
    end
`else
    always_comb begin
        gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt == '0 && req_vld[k]) begin
                gnt[k] = 1'b1;
            end
        end
    end
`endif

    assign req_rdy = grant_en ? gnt : '0;

    // Payload of the granted requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_rdy[k]) begin
                sel_addr = req_addr[k*AW +: AW];
                sel_data = req_data[k*DW +: DW];
            end
        end
    end

    assign accept  = |req_rdy;
    assign wr_live = accept && (sel_addr != '0);
    assign wr_drop = accept && (sel_addr == '0);

    // Halt sequencing: DRAIN waits for the registered write to retire.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (hlt)  state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!we)  state_nxt = ST_HALTED;
            ST_HALTED: if (!hlt) state_nxt = ST_RUN;
            default:             state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            hlt_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            hlt_done <= (state_nxt == ST_HALTED);
        end
    end

    // Write port register; R0 writes are swallowed and counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            we       <= 1'b0;
            dst_addr <= '0;
            dst      <= '0;
            drop_cnt <= '0;
        end else begin
            we <= wr_live;
            if (wr_live) begin
                dst_addr <= sel_addr;
                dst      <= sel_data;
            end
            if (wr_drop && drop_cnt != {CW{1'b1}}) begin
                drop_cnt <= drop_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Bench for rf_wr_arb: vector table, directed multi-cycle sequences and a randomized run against a reference model.
module tb_rf_wr_arb;

    localparam int NREQ = 3;
`ifdef RF_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  req_vld;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_rdy;
    logic        we;
    logic [3:0]  dst_addr;
    logic [15:0] dst;
    logic        hlt;
    logic        hlt_done;
    logic [7:0]  drop_cnt;

    rf_wr_arb #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .we       (we),
        .dst_addr (dst_addr),
        .dst      (dst),
        .hlt      (hlt),
        .hlt_done (hlt_done),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic [2:0] v,
                         input logic [11:0] a, input logic [47:0] d);
        rst      = r;
        hlt      = h;
        req_vld  = v;
        req_addr = a;
        req_data = d;
    endtask

    // Reference model: 0=run 1=drain 2=halted; m_last is the last granted requester.
    int          m_mode;
    int          m_last;
    logic        m_we;
    logic [3:0]  m_addr;
    logic [15:0] m_dst;
    int          m_drop;
    logic        m_done;

    task automatic model_reset();
        m_mode = 0;
        m_last = NREQ - 1;
        m_we   = 1'b0;
        m_addr = '0;
        m_dst  = '0;
        m_drop = 0;
        m_done = 1'b0;
    endtask

    function automatic int model_grant();
        int i;
        if (m_mode != 0 || hlt) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            i = RR ? (m_last + k) % NREQ : k - 1;
            if (req_vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input int g);
        logic [3:0] a;
        if (rst) begin
            model_reset();
            return;
        end
        m_we = 1'b0;
        if (g >= 0) begin
            a = req_addr[g*4 +: 4];
            if (a == 4'h0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_we   = 1'b1;
                m_addr = a;
                m_dst  = req_data[g*16 +: 16];
            end
            m_last = g;
        end
        case (m_mode)
            0: if (hlt) m_mode = 1;
            1: m_mode = 2;
            default: if (!hlt) m_mode = 0;
        endcase
        m_done = (m_mode == 2);
    endtask

    // Inputs are set at negedge before this is called.
    task automatic model_cycle();
        int g;
        logic [2:0] e_rdy;
        #1;
        g = model_grant();
        e_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk("rand_rdy", req_rdy, e_rdy);
        @(posedge clk);
        model_edge(g);
        #1;
        chk("rand_regs", {we, dst_addr, dst, drop_cnt, hlt_done},
            {m_we, m_addr, m_dst, 8'(m_drop), m_done});
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 3'b000, 12'h000, 48'h0);
        @(posedge clk);
        #1;
        model_reset();
        chk("reset_vals", {we, dst_addr, dst, drop_cnt, hlt_done}, 64'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 12'h000, 48'h0);
    endtask

    typedef struct {
        logic        rst;
        logic        hlt;
        logic [2:0]  vld;
        logic [11:0] addr;
        logic [47:0] data;
        logic [2:0]  e_rdy;
        logic        e_we;
        logic [3:0]  e_addr;
        logic [15:0] e_dst;
        logic [7:0]  e_drop;
        logic        e_done;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [2:0]  exp_g;
        logic [2:0]  v;
        logic [11:0] a;
        logic [47:0] d;
        logic        hr;
        int          we_hi;
        logic [3:0]  na;

        //           rst   hlt   vld     addr     data                  rdy     we    addr   dst       drop   done
        tbl[0]  = '{1'b0, 1'b0, 3'b001, 12'h005, 48'h0000_0000_A5A5, 3'b001, 1'b1, 4'h5, 16'hA5A5, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'b000, 12'h005, 48'h0000_0000_A5A5, 3'b000, 1'b0, 4'h5, 16'hA5A5, 8'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 3'b010, 12'h000, 48'h0000_1234_0000, 3'b010, 1'b0, 4'h5, 16'hA5A5, 8'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 3'b100, 12'hF00, 48'hBEEF_0000_0000, 3'b100, 1'b1, 4'hF, 16'hBEEF, 8'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'b001, 12'h003, 48'h0000_0000_1111, 3'b000, 1'b0, 4'hF, 16'hBEEF, 8'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'b001, 12'h003, 48'h0000_0000_1111, 3'b000, 1'b0, 4'hF, 16'hBEEF, 8'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 3'b000, 12'h003, 48'h0000_0000_1111, 3'b000, 1'b0, 4'hF, 16'hBEEF, 8'd1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 3'b001, 12'h003, 48'h0000_0000_1111, 3'b000, 1'b0, 4'hF, 16'hBEEF, 8'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 3'b001, 12'h003, 48'h0000_0000_1111, 3'b001, 1'b1, 4'h3, 16'h1111, 8'd1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'b001, 12'h007, 48'h0000_0000_2222, 3'b001, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 3'b000, 12'h000, 48'h0,              3'b000, 1'b0, 4'h0, 16'h0000, 8'd0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 3'b011, 12'h0A0, 48'h0000_7777_0000, 3'b001, 1'b0, 4'h0, 16'h0000, 8'd1, 1'b0};

        drive(1'b1, 1'b0, 3'b000, 12'h000, 48'h0);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 12'h000, 48'h0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].hlt, tbl[i].vld, tbl[i].addr, tbl[i].data);
            #1;
            chk($sformatf("vec%0d_rdy", i), req_rdy, tbl[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_regs", i), {we, dst_addr, dst, drop_cnt, hlt_done},
                {tbl[i].e_we, tbl[i].e_addr, tbl[i].e_dst, tbl[i].e_drop, tbl[i].e_done});
            @(negedge clk);
        end

        // All three requesters held valid for six cycles.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, 3'b111, 12'h321, 48'hCCCC_BBBB_AAAA);
            exp_g = RR ? 3'(c % 3) : 3'd0;
            #1;
            chk($sformatf("arb%0d_rdy", c), req_rdy, 3'(1 << exp_g));
            @(posedge clk);
            #1;
            chk($sformatf("arb%0d_we", c), {we, dst_addr}, {1'b1, 4'(exp_g + 1)});
            @(negedge clk);
        end

        // Halt during a stream, then resume with the saved pointer.
        do_reset();
        drive(1'b0, 1'b0, 3'b111, 12'h321, 48'hCCCC_BBBB_AAAA);
        #1; chk("halt_c0_rdy", req_rdy, 3'b001);
        @(posedge clk); @(negedge clk);
        #1; chk("halt_c1_rdy", req_rdy, RR ? 3'b010 : 3'b001);
        @(posedge clk); #1;
        chk("halt_c1_we", {we, dst_addr}, {1'b1, RR ? 4'h2 : 4'h1});
        @(negedge clk);
        hlt = 1'b1;
        #1; chk("halt_c2_rdy", req_rdy, 3'b000);
        @(posedge clk); #1;
        chk("halt_c2_out", {we, hlt_done}, 2'b00);
        @(negedge clk);
        #1; chk("halt_c3_rdy", req_rdy, 3'b000);
        @(posedge clk); #1;
        chk("halt_c3_done", {we, hlt_done}, 2'b01);
        @(negedge clk);
        hlt = 1'b0;
        #1; chk("halt_c4_rdy", req_rdy, 3'b000);
        @(posedge clk); #1;
        chk("halt_c4_out", {we, hlt_done}, 2'b00);
        @(negedge clk);
        #1; chk("halt_c5_rdy", req_rdy, RR ? 3'b100 : 3'b001);
        @(posedge clk); #1;
        chk("halt_c5_we", {we, dst_addr}, {1'b1, RR ? 4'h3 : 4'h1});
        @(negedge clk);

        // 300 writes to R0: never visible, counter saturates.
        do_reset();
        we_hi = 0;
        for (int n = 1; n <= 300; n++) begin
            drive(1'b0, 1'b0, 3'b001, 12'h000, 48'(n));
            @(posedge clk);
            #1;
            if (we) we_hi++;
            if (n == 100) chk("drop_100", drop_cnt, 8'd100);
            if (n == 255) chk("drop_255", drop_cnt, 8'hFF);
            @(negedge clk);
        end
        chk("drop_we_never", we_hi, 0);
        chk("drop_sat", drop_cnt, 8'hFF);

        // Randomized run against the reference model.
        do_reset();
        hr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(11, 0) == 0) hr = ~hr;
            v = 3'($urandom);
            for (int j = 0; j < 3; j++) begin
                na = ($urandom_range(3, 0) == 0) ? 4'h0 : 4'($urandom);
                a[j*4 +: 4] = na;
                d[j*16 +: 16] = 16'($urandom);
            end
            drive(($urandom_range(99, 0) == 0), hr, v, a, d);
            model_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 The block SHALL have one clock, clk, and one synchronous active-high reset, rst; all state SHALL change only on posedge clk.
REQ-002 Parameter NREQ, default 3: number of write requesters (2..4).
REQ-003 Ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- req_vld  in  NREQ  requester i holds a write
- req_addr  in  4*NREQ  requester i destination register (slice i)
- req_data  in  16*NREQ  requester i write data (slice i)
- req_rdy  out  NREQ  one-hot grant; a transfer occurs when req_vld[i] and req_rdy[i] are high on a posedge
- we  out  1  register-file write enable
- dst_addr  out  4  register-file write address
- dst  out  16  register-file write data
- hlt  in  1  halt request
- hlt_done  out  1  halted, write port quiescent
- drop_cnt  out  8  count of writes dropped to R0

Function
REQ-004 req_rdy SHALL be combinational from the req_vld, pointer and state, and SHALL have at most one bit set.
REQ-005 req_rdy SHALL be all-zero when the state is not RUN.
REQ-006 An accepted transfer SHALL appear on we/dst_addr/dst exactly one cycle after acceptance; the outputs are registered.
REQ-007 we SHALL be low in any cycle that follows a cycle with no accepted transfer; dst_addr and dst SHALL hold their previous values.
REQ-008 An accepted transfer with address 4'h0 SHALL be consumed with we low, and drop_cnt SHALL increment by 1, saturating at 8'hFF.
REQ-009 Sustained throughput SHALL be one transfer per cycle, with no bubble between back-to-back grants.
REQ-010 With RF_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the requester after the last granted one, and the pointer advances only on an accepted transfer.
REQ-011 A requester that deasserts req_vld without a transfer SHALL leave the pointer unchanged.
REQ-012 The state machine SHALL have three states: RUN, DRAIN and HALTED.
- RUN: if hlt is high, go to DRAIN.
- DRAIN: no grants; go to HALTED after one cycle, once the final registered write has retired.
- HALTED: hlt_done=1; when hlt falls, go to RUN.
- hlt_done SHALL be 1 only in HALTED.
REQ-013 When hlt rises in the same cycle as a valid request, that request SHALL NOT be granted.
REQ-014 After the transition to RUN, the pointer SHALL be unchanged from its value before the halt.

Reset
REQ-015 rst SHALL take priority over all other inputs.
REQ-016 Reset values SHALL be:
- state = RUN
- we = 0
- dst_addr = 4'h0, dst = 16'h0
- drop_cnt = 8'h0
- round-robin pointer such that requester 0 has highest priority
- req_rdy reflects reset state next cycle
REQ-017 Reset asserted while a registered write is pending SHALL cancel it: we = 0 in the next cycle.

Configuration
REQ-018 Macro RF_ARB_RR_EN:
- defined: round-robin arbitration per REQ-010.
- undefined: fixed priority, lowest index wins, and no pointer state is implemented.
- all other behaviour SHALL be identical in both builds.

Verification
REQ-019 A bench SHALL cover these directed scenarios:
- Single write: req_vld=3'b001, addr 5, data 16'hA5A5 → req_rdy=001; next cycle we=1, dst_addr=5, dst=16'hA5A5.
- Round-robin (RF_ARB_RR_EN defined): all three requesters held valid for 6 cycles → grants 0,1,2,0,1,2; we high on 6 consecutive cycles.
- Fixed priority (RF_ARB_RR_EN undefined): same stimulus → requester 0 granted on all 6 cycles.
- R0 drop: 300 accepted writes to address 0 → we never high; drop_cnt=8'hFF.
- Halt: assert hlt during a stream → no grants from that cycle; last write retires; hlt_done=1 two cycles after hlt rises; deassert hlt → grants resume with the previous pointer.
- Reset mid-stream: rst high in the cycle after an acceptance → we=0 next cycle; all outputs at reset values.
